array_arbiter: RTL and testbench
================================

# array_arbiter

Two-client arbiter that shares the single port of an `array` memory between two independent address/data request streams. It accepts reads and writes from client 0 and client 1 with round-robin fairness, sequences the one-cycle array read latency, and returns each read result on that client's own response stream with backpressure. It sits between the `array` instance and stream-level consumers such as `io_stream_read_write_array`.

## Interface

**Parameters**
- `intN`, 8: data width.
- `addrN`, 8: address width.

**Ports**
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `c0_addr`, `c1_addr`  in  addrN  request address.
- `c0_data`, `c1_data`  in  intN  write data; ignored for reads.
- `c0_we`, `c1_we`  in  1  1 = write, 0 = read.
- `c0_valid`, `c1_valid`  in  1  request valid.
- `c0_ready`, `c1_ready`  out  1  request accepted this cycle (grant).
- `r0`, `r1`  out  intN  read response data.
- `r0_valid`, `r1_valid`  out  1  response valid.
- `r0_ready`, `r1_ready`  in  1  response consumer ready.
- `arr_addr`  out  addrN  array address.
- `arr_di`  out  intN  array write data.
- `arr_we`  out  1  array write enable.
- `arr_do`  in  intN  array read data, valid the cycle after a read address is presented.

## Operation

- A request transfers when `cK_valid && cK_ready`. A response transfers when `rK_valid && rK_ready`.
- At most one request is granted per cycle. `cK_ready` is combinational from the valids, the FSM state and the round-robin pointer, and may depend on `cK_valid`.
- **Round robin:** `last` records the most recently granted client.
  - If both clients are eligible, grant `!last`.
  - If one client is eligible, grant that client.
  - `last` updates on every grant.
- **Array drive:** on a grant, `arr_addr`, `arr_di` and `arr_we` come combinationally from the granted client. With no grant, `arr_we = 0` and `arr_addr`/`arr_di` hold their last granted values.
- **FSM states:**
  - **IDLE:** reads and writes may be granted.
    - Granted write → IDLE.
    - Granted read → RD_WAIT; owner id is latched.
  - **RD_WAIT:** nothing is granted. Capture `arr_do` into the response register → HOLD.
  - **HOLD:** `r<owner>_valid = 1` and `r<owner> =` captured data. The other client's `rK_valid` stays 0.
    - Without a response transfer, only writes may be granted (either client); reads are not granted.
    - On a response transfer in the same cycle, the state behaves as IDLE, so a read may be granted. Next state: RD_WAIT if a read is granted, else IDLE.
- **Hazard ordering:** a write granted in HOLD never alters the captured response.
- **Reset (`rst = 1`):**
  - State → IDLE; `last` → 1, so client 0 wins the first tie.
  - `r0_valid = r1_valid = 0`; response register and owner cleared to 0.
  - `c0_ready = c1_ready = 0` and `arr_we = 0` while `rst` is high.
  - A read in flight (RD_WAIT or HOLD) is dropped; no response is ever produced for it.

## Timing

- **Write:** granted in cycle t; array updated at the posedge ending t. A read of the same address granted in t+1 returns the new value.
- **Read:**
  - Granted in cycle t.
  - `arr_do` valid in t+1 (RD_WAIT) and captured at the end of t+1.
  - `rK_valid = 1` from t+2.
  - Minimum latency: 2 cycles.
- **Throughput:** back-to-back reads with responses consumed immediately: one read per 2 cycles. Writes: one per cycle.
- **Response hold:** response data is stable while `rK_valid && !rK_ready`.

## Structure

- The shared header (alongside `primitives.v`) holds:
  - `intN`/`addrN` defaults and `intT`/`addrT`.
  - FSM state encodings `ARB_IDLE=2'd0`, `ARB_RD_WAIT=2'd1`, `ARB_HOLD=2'd2`.
- One sub-module: `rr_arbiter2`.
  - Inputs: `clk`, `rst`, `req[1:0]`, `en`.
  - Outputs: one-hot `gnt[1:0]`.
  - Owns the `last` register; `en` gates the eligibility and the pointer update.
- The FSM, response register and array muxing live in `array_arbiter`.

## Test plan

- Client 0 writes `addr i = i*7` for i = 0..7, then client 1 reads i = 0..7 with `r1_ready = 1` → `r1` = 0,7,14,…,49 in order; each `r1_valid` is exactly 2 cycles after its grant; `r0_valid` stays 0.
- Both clients hold read requests continuously (c0 addr 3, c1 addr 5) after preload → grants alternate c0,c1,c0,c1 starting with c0; `r0 = 21`, `r1 = 35`; one read every 2 cycles.
- Client 0 read of addr 2, with `r0_ready = 0` for 5 cycles → `r0_valid` and `r0 = 14` held steady. Client 1 write of addr 2 = 99 is granted during HOLD. A client 1 read is not granted until `r0` transfers, then returns 99.
- Same-cycle write (c0, addr 4 = 50) and read (c1, addr 4) after reset → c0 granted first (tie rule); c1 granted next cycle and reads 50.
- `rst` asserted in the RD_WAIT cycle of a client 1 read → `r1_valid` never rises. After release, the first tie grants client 0 and the array contents are unchanged.
- Hold `r0_ready = 1` through a read whose response transfers in the same cycle a new c0 read is presented → new read granted in that cycle; second response follows 2 cycles later.

Source files
------------

// File: rtl/array_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_arbiter_pkg
//  Description : Shared widths, types and FSM state encodings for the
//                two-client array arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package array_arbiter_pkg;

    localparam int INT_N  = 8;
    localparam int ADDR_N = 8;

    typedef logic [INT_N-1:0]  intT;
    typedef logic [ADDR_N-1:0] addrT;

    // Arbiter FSM encodings
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_RD_WAIT = 2'd1;
    localparam logic [1:0] ARB_HOLD    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin arbiter with one-hot grant. The
//                pointer names the most recently granted requester; on a tie
//                the other one wins. en masks all requests and freezes the
//                pointer.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import array_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic       r_last;
    logic [1:0] w_req;

    assign w_req = en ? req : 2'b00;

    // Grant the sole requester, or on a tie the one not granted last time
    always_comb begin
        gnt = w_req;
        if (w_req == 2'b11) begin
            gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    // Pointer tracks the last granted client; reset value lets client 0 win first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|gnt) begin
            r_last <= gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/array_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : array_arbiter
//  Description : Shares one single-port array between two request streams.
//                Reads are sequenced through the one-cycle array latency
//                (IDLE -> RD_WAIT -> HOLD) and returned on the owning client's
//                response stream with backpressure. Writes may proceed while a
//                response is parked in HOLD.
//  Revision    : 1.0  initial release
// ============================================================================
module array_arbiter
    import array_arbiter_pkg::*;
#(
    parameter int intN  = INT_N,
    parameter int addrN = ADDR_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [addrN-1:0] c0_addr,
    input  logic [addrN-1:0] c1_addr,
    input  logic [intN-1:0]  c0_data,
    input  logic [intN-1:0]  c1_data,
    input  logic             c0_we,
    input  logic             c1_we,
    input  logic             c0_valid,
    input  logic             c1_valid,
    output logic             c0_ready,
    output logic             c1_ready,
    output logic [intN-1:0]  r0,
    output logic [intN-1:0]  r1,
    output logic             r0_valid,
    output logic             r1_valid,
    input  logic             r0_ready,
    input  logic             r1_ready,
    output logic [addrN-1:0] arr_addr,
    output logic [intN-1:0]  arr_di,
    output logic             arr_we,
    input  logic [intN-1:0]  arr_do
);

    logic [1:0]       r_state;
    logic             r_owner;
    logic [intN-1:0]  r_resp;
    logic [addrN-1:0] r_addr_hold;
    logic [intN-1:0]  r_di_hold;

    logic             w_rsp_xfer;
    logic             w_free;
    logic             w_en;
    logic [1:0]       w_req;
    logic [1:0]       w_gnt;
    logic             w_any_gnt;
    logic [addrN-1:0] w_sel_addr;
    logic [intN-1:0]  w_sel_data;
    logic             w_sel_we;
    logic             w_rd_gnt;

    // A parked response leaving this cycle frees the port for a new read
    assign w_rsp_xfer = (r_state == ARB_HOLD) && (r_owner ? r1_ready : r0_ready);
    assign w_free     = (r_state == ARB_IDLE) || w_rsp_xfer;

    // In HOLD without a transfer only writes are eligible; the captured
    // response lives in r_resp, so writes cannot disturb it
    assign w_req[0] = c0_valid && (w_free || ((r_state == ARB_HOLD) && c0_we));
    assign w_req[1] = c1_valid && (w_free || ((r_state == ARB_HOLD) && c1_we));
    assign w_en     = !rst && (r_state != ARB_RD_WAIT);

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .en  (w_en),
        .gnt (w_gnt)
    );

    assign c0_ready   = w_gnt[0];
    assign c1_ready   = w_gnt[1];
    assign w_any_gnt  = |w_gnt;
    assign w_sel_addr = w_gnt[1] ? c1_addr : c0_addr;
    assign w_sel_data = w_gnt[1] ? c1_data : c0_data;
    assign w_sel_we   = w_gnt[1] ? c1_we   : c0_we;
    assign w_rd_gnt   = w_any_gnt && !w_sel_we;

    assign arr_addr = w_any_gnt ? w_sel_addr : r_addr_hold;
    assign arr_di   = w_any_gnt ? w_sel_data : r_di_hold;
    assign arr_we   = w_any_gnt && w_sel_we;

    assign r0       = r_resp;
    assign r1       = r_resp;
    assign r0_valid = (r_state == ARB_HOLD) && !r_owner;
    assign r1_valid = (r_state == ARB_HOLD) &&  r_owner;

    // Keep the array address/data steady between grants
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hold <= '0;
            r_di_hold   <= '0;
        end else if (w_any_gnt) begin
            r_addr_hold <= w_sel_addr;
            r_di_hold   <= w_sel_data;
        end
    end

    // Read sequencing FSM: latch owner on read grant, capture array data, park it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_owner <= 1'b0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_rd_gnt) begin
                        r_state <= ARB_RD_WAIT;
                        r_owner <= w_gnt[1];
                    end
                end
                ARB_RD_WAIT: begin
                    r_resp  <= arr_do;
                    r_state <= ARB_HOLD;
                end
                ARB_HOLD: begin
                    if (w_rsp_xfer) begin
                        if (w_rd_gnt) begin
                            r_state <= ARB_RD_WAIT;
                            r_owner <= w_gnt[1];
                        end else begin
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_array_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_arbiter
//  Description : Self-checking bench for array_arbiter. A behavioural array
//                sits on the array port; a transaction-level model predicts
//                grants, array drive and responses every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_array_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] c0_addr, c1_addr, c0_data, c1_data;
    logic       c0_we, c1_we, c0_valid, c1_valid;
    logic       c0_ready, c1_ready;
    logic [7:0] r0, r1;
    logic       r0_valid, r1_valid, r0_ready, r1_ready;
    logic [7:0] arr_addr, arr_di, arr_do;
    logic       arr_we;

    array_arbiter #(.intN(8), .addrN(8)) dut (
        .clk(clk), .rst(rst),
        .c0_addr(c0_addr), .c1_addr(c1_addr),
        .c0_data(c0_data), .c1_data(c1_data),
        .c0_we(c0_we), .c1_we(c1_we),
        .c0_valid(c0_valid), .c1_valid(c1_valid),
        .c0_ready(c0_ready), .c1_ready(c1_ready),
        .r0(r0), .r1(r1),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .arr_addr(arr_addr), .arr_di(arr_di), .arr_we(arr_we),
        .arr_do(arr_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port array with one-cycle registered read
    logic [7:0] tb_mem [256];
    always @(posedge clk) begin
        if (arr_we) tb_mem[arr_addr] <= arr_di;
        arr_do <= tb_mem[arr_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding read is described by its client, the
    // data it must return and how many cycles ago it was granted.
    logic [7:0] m_mem [256];
    bit         m_last = 1'b1;
    bit         m_active = 1'b0;
    int         m_age = 0;
    bit         m_cl = 1'b0;
    logic [7:0] m_data = 8'd0;
    bit         m_hold_ok = 1'b0;
    logic [7:0] m_hold_addr = 8'd0, m_hold_di = 8'd0;
    bit [1:0]   m_g;

    // One clock: inputs already applied at the preceding negedge
    task automatic cycle();
        bit [1:0]   v, w, elig, g;
        logic [7:0] a [2];
        logic [7:0] d [2];
        bit         vis, xfer, k;
        #1;
        v = {c1_valid, c0_valid};
        w = {c1_we, c0_we};
        a[0] = c0_addr; a[1] = c1_addr;
        d[0] = c0_data; d[1] = c1_data;
        vis  = m_active && (m_age >= 2);
        xfer = vis && (m_cl ? r1_ready : r0_ready);
        for (int i = 0; i < 2; i++)
            elig[i] = !rst && v[i] && (!m_active || (vis && (xfer || w[i])));
        if (elig == 2'b11) g = m_last ? 2'b01 : 2'b10;
        else               g = elig;
        m_g = g;
        k = g[1];

        chk_eq("c0_ready", c0_ready, g[0]);
        chk_eq("c1_ready", c1_ready, g[1]);
        chk_eq("arr_we", arr_we, (g != 0) && w[k]);
        if (g != 0) begin
            chk_eq("arr_addr", arr_addr, a[k]);
            chk_eq("arr_di", arr_di, d[k]);
        end else if (m_hold_ok) begin
            chk_eq("arr_addr_hold", arr_addr, m_hold_addr);
            chk_eq("arr_di_hold", arr_di, m_hold_di);
        end
        chk_eq("r0_valid", r0_valid, vis && !m_cl);
        chk_eq("r1_valid", r1_valid, vis && m_cl);
        if (vis && !m_cl) chk_eq("r0_data", r0, m_data);
        if (vis &&  m_cl) chk_eq("r1_data", r1, m_data);

        @(posedge clk);
        if (rst) begin
            m_active  = 1'b0;
            m_last    = 1'b1;
            m_hold_ok = 1'b0;
        end else begin
            if (xfer)          m_active = 1'b0;
            else if (m_active) m_age++;
            if (g != 0) begin
                m_last      = k;
                m_hold_ok   = 1'b1;
                m_hold_addr = a[k];
                m_hold_di   = d[k];
                if (w[k]) begin
                    m_mem[a[k]] = d[k];
                end else begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_cl     = k;
                    m_data   = m_mem[a[k]];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Run until the model grants client k, bounded
    task automatic run_until(input int k);
        bit done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            cycle();
            if (m_g[k]) done = 1'b1;
        end
        if (!done) chk_eq("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_c0(input bit v, input bit we, input logic [7:0] ad, input logic [7:0] dt);
        c0_valid = v; c0_we = we; c0_addr = ad; c0_data = dt;
    endtask

    task automatic set_c1(input bit v, input bit we, input logic [7:0] ad, input logic [7:0] dt);
        c1_valid = v; c1_we = we; c1_addr = ad; c1_data = dt;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'd0;
            m_mem[i]  = 8'd0;
        end
        rst = 1'b1;
        r0_ready = 1'b1; r1_ready = 1'b1;
        set_c0(1, 0, 8'd1, 8'd0);
        set_c1(1, 1, 8'd2, 8'd3);
        @(negedge clk);
        cycles(2);                       // requests must be refused during reset
        rst = 1'b0;
        set_c0(0, 0, 8'd0, 8'd0);
        set_c1(0, 0, 8'd0, 8'd0);
        cycle();

        // Preload addr i = i*7 from client 0, read back via client 1
        for (int i = 0; i < 8; i++) begin
            set_c0(1, 1, 8'(i), 8'(i * 7));
            run_until(0);
        end
        set_c0(0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            set_c1(1, 0, 8'(i), 8'd0);
            run_until(1);
            set_c1(0, 0, 8'd0, 8'd0);
        end
        cycles(3);

        // Both clients read continuously: alternating grants
        set_c0(1, 0, 8'd3, 8'd0);
        set_c1(1, 0, 8'd5, 8'd0);
        cycles(12);
        set_c0(0, 0, 8'd0, 8'd0);
        set_c1(0, 0, 8'd0, 8'd0);
        cycles(3);

        // Backpressured response with a write to the same address during HOLD
        r0_ready = 1'b0;
        set_c0(1, 0, 8'd2, 8'd0);
        run_until(0);
        set_c0(0, 0, 8'd0, 8'd0);
        set_c1(1, 1, 8'd2, 8'd99);
        run_until(1);
        set_c1(1, 0, 8'd2, 8'd0);
        cycles(5);
        r0_ready = 1'b1;
        run_until(1);
        set_c1(0, 0, 8'd0, 8'd0);
        cycles(4);

        // Same-cycle write/read tie straight after reset
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        set_c0(1, 1, 8'd4, 8'd50);
        set_c1(1, 0, 8'd4, 8'd0);
        run_until(0);
        set_c0(0, 0, 8'd0, 8'd0);
        run_until(1);
        set_c1(0, 0, 8'd0, 8'd0);
        cycles(4);

        // Reset during RD_WAIT drops the read
        set_c1(1, 0, 8'd6, 8'd0);
        run_until(1);
        set_c1(0, 0, 8'd0, 8'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycles(4);
        set_c0(1, 0, 8'd7, 8'd0);
        set_c1(1, 0, 8'd1, 8'd0);
        cycle();
        chk_eq("tie_after_reset_c0", m_g, 2'b01);
        set_c0(0, 0, 8'd0, 8'd0);
        run_until(1);
        set_c1(0, 0, 8'd0, 8'd0);
        cycles(4);

        // Continuous client 0 reads with immediate consumption
        set_c0(1, 0, 8'd1, 8'd0);
        cycles(10);
        set_c0(0, 0, 8'd0, 8'd0);
        cycles(3);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            r0_ready = ($urandom_range(0, 3) != 0);
            r1_ready = ($urandom_range(0, 3) != 0);
            set_c0($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   8'($urandom_range(0, 15)), 8'($urandom));
            set_c1($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   8'($urandom_range(0, 15)), 8'($urandom));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
